scene_sequencer: RTL
====================

// Module: scene_sequencer
// PURPOSE
//  Game-flow controller for the VGA output path. Sequences title -> level -> game-over scenes.
//  Drives scene_sel to pick which mapper's RGB is shown. Fades the selected pixel stream
//  through black between scenes. Registered pixel output, 1-cycle latency.
// PARAMETERS
//  H_ACTIVE     640  visible columns; DrawX==H_ACTIVE-1 is the last visible pixel
//  V_ACTIVE     480  visible rows; DrawY==V_ACTIVE-1 is the last visible line
//  FADE_FRAMES  4    frame_ticks per fade step (>=1)
//  HOLD_FRAMES  180  frame_ticks game-over scene is held before returning to title (>=1)
// PORTS
//  vga_clk      in   1   pixel clock, sole clock
//  reset_n      in   1   asynchronous reset, active-low
//  DrawX        in   10  current pixel column
//  DrawY        in   10  current pixel row
//  blank        in   1   1 = visible region, 0 = blanking
//  start_btn    in   1   start request (level or pulse)
//  player_dead  in   1   level-lost event
//  level_clear  in   1   level-won event
//  pix_red/green/blue in 4 each  RGB of the mapper currently selected by scene_sel
//  scene_sel    out  2   scene_pkg::scene_t: TITLE=0, LEVEL=1, GAMEOVER=2
//  fade_level   out  5   0..16 brightness; 16 = full
//  frame_tick   out  1   1-cycle pulse, cycle after DrawX==H_ACTIVE-1 && DrawY==V_ACTIVE-1
//  red/green/blue out 4 each  faded pixel output
// BEHAVIOUR
//  Reset values: state=S_TITLE, scene_sel=TITLE, fade_level=16, frame_tick=0, RGB=0.
//  Reset values also apply to all counters and pending bits, immediately, in any state.
//  Pixel path: out = (pix*fade_level)>>4. 4b x 5b -> 9b product, bits [7:4] kept (16 -> exact).
//   Registered; output is 0 whenever blank==0 in the input cycle.
//  Events: start/dead/clear each set a sticky pending bit on any cycle.
//   Pending bits are evaluated only on frame_tick. All pending bits clear on every state change.
//   Events during fades are therefore discarded.
//  States (transitions only on frame_tick):
//   S_TITLE:    pend_start -> S_FADE_OUT, next=LEVEL.
//   S_PLAY:     pend_dead -> FADE_OUT next=GAMEOVER; else pend_clear -> FADE_OUT next=TITLE.
//               When both are pending, dead wins.
//   S_GAMEOVER: hold_cnt counts ticks. At HOLD_FRAMES, or on pend_start -> FADE_OUT next=TITLE.
//   S_FADE_OUT: step_cnt counts ticks; every FADE_FRAMES-th tick is a step.
//               Step with level>0: level--.
//               Step with level==0: scene_sel<=next and -> S_FADE_IN. Gives one full black step.
//   S_FADE_IN:  each step level++. On reaching 16, go (same cycle) to the resident state of
//               scene_sel: TITLE->S_TITLE, LEVEL->S_PLAY, GAMEOVER->S_GAMEOVER.
//  step_cnt/hold_cnt are zeroed on entry to every state.
//  Timing: FADE_OUT = 17*FADE_FRAMES ticks; FADE_IN = 16*FADE_FRAMES ticks.
//  frame_tick is generated internally; there is no dependence on vsync.
// CONFIGURATION
//  SCENE_FADE_EN defined: fades as above.
//  SCENE_FADE_EN undefined: fade states are never entered and fade_level is constant 16.
//   Qualifying frame_tick sets scene_sel directly and goes to the resident state (hard cut).
//   The pixel path still registers, latency 1.
// STRUCTURE
//  scene_pkg: scene_t enum, state_t enum, FADE_MAX=16, FADE_W=5.
//  Sub-module fade_scaler: 3x 4b*5b multiply plus blank gating plus output register.
//  FSM, counters and frame_tick generation live in scene_sequencer.
// TESTING
//  1 frame_tick: DrawX=639, DrawY=479 for 1 cycle -> frame_tick=1 exactly on the next cycle only.
//  2 scaler: level=16, pix=F/8/0 -> F/8/0. Level 8, red=F -> 7. blank=0 -> 0/0/0 next cycle.
//  3 title->level: 1-cycle start_btn in S_TITLE, FADE_FRAMES=4 -> fade_level steps 16..0.
//    scene_sel=LEVEL after 68 ticks; fade_level 0..16; S_PLAY after 64 more ticks.
//  4 priority: player_dead and level_clear in same frame in S_PLAY -> next=GAMEOVER.
//    level_clear pulse during FADE_OUT is ignored.
//  5 game-over hold: no input -> FADE_OUT to TITLE begins at tick 180.
//    start_btn at tick 10 -> fade begins at tick 10's frame_tick.
//  6 reset mid-fade: reset_n low asynchronously during FADE_OUT with level=9 ->
//    scene_sel=TITLE, fade_level=16, RGB=0 without a clock edge.

Source files
------------

// File: rtl/scene_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// scene_pkg
// Shared types and constants for the scene sequencer:
//   scene_t       : which mapper's RGB is on screen (TITLE / LEVEL / GAMEOVER)
//   state_t       : sequencer FSM states
//   FADE_MAX      : full-brightness fade level
//   FADE_W        : width of the fade level (0..FADE_MAX)
//   resident_state: scene -> the FSM state that idles in that scene
//   scale_pix     : one colour channel scaled by the fade level
// -----------------------------------------------------------------------------
package scene_pkg;

  typedef enum logic [1:0] {
    TITLE    = 2'd0,
    LEVEL    = 2'd1,
    GAMEOVER = 2'd2
  } scene_t;

  typedef enum logic [2:0] {
    S_TITLE    = 3'd0,
    S_PLAY     = 3'd1,
    S_GAMEOVER = 3'd2,
    S_FADE_OUT = 3'd3,
    S_FADE_IN  = 3'd4
  } state_t;

  localparam int FADE_MAX = 16;
  localparam int FADE_W   = 5;

  function automatic state_t resident_state(input scene_t s);
    state_t r;
    case (s)
      TITLE:    r = S_TITLE;
      LEVEL:    r = S_PLAY;
      GAMEOVER: r = S_GAMEOVER;
      default:  r = S_TITLE;
    endcase
    return r;
  endfunction

  // (pix * lvl) >> 4. The product never exceeds 15*16 = 240, so 8 bits hold
  // it exactly and level 16 passes the pixel through unchanged.
  function automatic logic [3:0] scale_pix(input logic [3:0] pix,
                                           input logic [FADE_W-1:0] lvl);
    return 4'(({4'b0000, pix} * {3'b000, lvl}) >> 4);
  endfunction

endpackage

// File: rtl/scene_sequencer_if.sv
// -----------------------------------------------------------------------------
// scene_sequencer_if
// Groups the VGA-side signals of the scene sequencer.
//   master: raster position, blank, game events, selected mapper RGB (drives);
//           scene_sel, fade_level, frame_tick, faded RGB (receives)
//   slave : the sequencer side (mirror of master)
// -----------------------------------------------------------------------------
interface scene_sequencer_if;
  import scene_pkg::*;

  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              blank;
  logic              start_btn;
  logic              player_dead;
  logic              level_clear;
  logic [3:0]        pix_red;
  logic [3:0]        pix_green;
  logic [3:0]        pix_blue;
  scene_t            scene_sel;
  logic [FADE_W-1:0] fade_level;
  logic              frame_tick;
  logic [3:0]        red;
  logic [3:0]        green;
  logic [3:0]        blue;

  modport master (
    output DrawX, DrawY, blank, start_btn, player_dead, level_clear,
           pix_red, pix_green, pix_blue,
    input  scene_sel, fade_level, frame_tick, red, green, blue
  );

  modport slave (
    input  DrawX, DrawY, blank, start_btn, player_dead, level_clear,
           pix_red, pix_green, pix_blue,
    output scene_sel, fade_level, frame_tick, red, green, blue
  );

endinterface

// File: rtl/scene_sequencer_fade_scaler.sv
// -----------------------------------------------------------------------------
// fade_scaler
// Scales the selected mapper's RGB by the fade level and registers it.
// Output is forced to black when the input cycle is in blanking.
//   clk, rst_n            : pixel clock, async active-low reset
//   level_i               : brightness 0..16
//   blank_i               : 1 = visible pixel
//   pix_{r,g,b}_i         : unscaled 4-bit colour
//   red_o/green_o/blue_o  : scaled colour, one cycle later
// -----------------------------------------------------------------------------
module fade_scaler
  import scene_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FADE_W-1:0] level_i,
  input  logic              blank_i,
  input  logic [3:0]        pix_r_i,
  input  logic [3:0]        pix_g_i,
  input  logic [3:0]        pix_b_i,
  output logic [3:0]        red_o,
  output logic [3:0]        green_o,
  output logic [3:0]        blue_o
);

  logic [3:0] red_d, green_d, blue_d;
  logic [3:0] red_q, green_q, blue_q;

  // Scale each channel, or black during blanking.
  always_comb begin
    if (blank_i) begin
      red_d   = scale_pix(pix_r_i, level_i);
      green_d = scale_pix(pix_g_i, level_i);
      blue_d  = scale_pix(pix_b_i, level_i);
    end else begin
      red_d   = 4'd0;
      green_d = 4'd0;
      blue_d  = 4'd0;
    end
  end

  // Output pixel register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_q   <= 4'd0;
      green_q <= 4'd0;
      blue_q  <= 4'd0;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign red_o   = red_q;
  assign green_o = green_q;
  assign blue_o  = blue_q;

endmodule

// File: rtl/scene_sequencer.sv
// -----------------------------------------------------------------------------
// scene_sequencer
// Game-flow controller for the VGA path: title -> level -> game-over scenes,
// with fade-through-black between scenes.
//   vga_clk  : pixel clock (sole clock)
//   reset_n  : asynchronous active-low reset
//   bus      : scene_sequencer_if.slave (raster, blank, events, pixel in/out,
//              scene_sel, fade_level, frame_tick)
// Build option: define SCENE_FADE_EN to enable fades; when undefined a
// qualifying frame_tick hard-cuts straight to the new scene and fade_level
// stays at 16.
// -----------------------------------------------------------------------------
module scene_sequencer
  import scene_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int FADE_FRAMES = 4,
  parameter int HOLD_FRAMES = 180
)(
  input  logic vga_clk,
  input  logic reset_n,
  scene_sequencer_if.slave bus
);

  localparam int STEP_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
  localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FADE_FRAMES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [9:0]        X_LAST    = 10'(H_ACTIVE - 1);
  localparam logic [9:0]        Y_LAST    = 10'(V_ACTIVE - 1);
  localparam logic [FADE_W-1:0] LVL_FULL  = FADE_W'(FADE_MAX);
  localparam logic [FADE_W-1:0] LVL_TOP   = FADE_W'(FADE_MAX - 1);
  localparam logic [FADE_W-1:0] LVL_ZERO  = {FADE_W{1'b0}};

  state_t            state_q, state_d;
  scene_t            scene_q, scene_d;
  scene_t            next_q, next_d;
  logic [FADE_W-1:0] level_q, level_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [2:0]        pend_q, pend_d;   // {start, dead, clear}
  logic              tick_q, tick_d;

  logic [2:0] pend_now_s;
  logic       step_s;
  logic       leave_s;
  scene_t     target_s;
  logic       state_chg_s;

  assign tick_d      = (bus.DrawX == X_LAST) && (bus.DrawY == Y_LAST);
  // An event arriving on the tick cycle itself still counts for that tick.
  assign pend_now_s  = pend_q | {bus.start_btn, bus.player_dead, bus.level_clear};
  assign step_s      = tick_q && (step_q == STEP_LAST);
  assign state_chg_s = (state_d != state_q);

  // State and datapath registers.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_TITLE;
      scene_q <= TITLE;
      next_q  <= TITLE;
      level_q <= LVL_FULL;
      step_q  <= {STEP_W{1'b0}};
      hold_q  <= {HOLD_W{1'b0}};
      pend_q  <= 3'b000;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      scene_q <= scene_d;
      next_q  <= next_d;
      level_q <= level_d;
      step_q  <= step_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      tick_q  <= tick_d;
    end
  end

  // Next-state logic: scene requests from resident states, fade progress.
  always_comb begin
    leave_s  = 1'b0;
    target_s = TITLE;
    state_d  = state_q;
    case (state_q)
      S_TITLE: begin
        if (tick_q && pend_now_s[2]) begin
          leave_s  = 1'b1;
          target_s = LEVEL;
        end else begin
          leave_s  = 1'b0;
        end
      end
      S_PLAY: begin
        // Death outranks a simultaneous clear.
        if (tick_q && pend_now_s[1]) begin
          leave_s  = 1'b1;
          target_s = GAMEOVER;
        end else if (tick_q && pend_now_s[0]) begin
          leave_s  = 1'b1;
          target_s = TITLE;
        end else begin
          leave_s  = 1'b0;
        end
      end
      S_GAMEOVER: begin
        if (tick_q && (pend_now_s[2] || (hold_q == HOLD_LAST))) begin
          leave_s  = 1'b1;
          target_s = TITLE;
        end else begin
          leave_s  = 1'b0;
        end
      end
      S_FADE_OUT: begin
        // The step taken at level 0 is the extra all-black step.
        if (step_s && (level_q == LVL_ZERO)) begin
          state_d = S_FADE_IN;
        end else begin
          state_d = state_q;
        end
      end
      S_FADE_IN: begin
        if (step_s && (level_q == LVL_TOP)) begin
          state_d = resident_state(scene_q);
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = S_TITLE;
    endcase

    if (leave_s) begin
`ifdef SCENE_FADE_EN
      state_d = S_FADE_OUT;
`else
      state_d = resident_state(target_s);
`endif
    end else begin
      state_d = state_d;
    end
  end

  // Datapath: counters, pending events, fade level and scene selection.
  always_comb begin
    scene_d = scene_q;
    next_d  = next_q;
    level_d = level_q;
    step_d  = step_q;
    hold_d  = hold_q;
    pend_d  = pend_now_s;

    if (state_chg_s) begin
      step_d = {STEP_W{1'b0}};
      hold_d = {HOLD_W{1'b0}};
      pend_d = 3'b000;
    end else if (tick_q) begin
      case (state_q)
        S_FADE_OUT, S_FADE_IN: step_d = step_s ? {STEP_W{1'b0}} : step_q + STEP_W'(1);
        S_GAMEOVER:            hold_d = hold_q + HOLD_W'(1);
        default:               step_d = step_q;
      endcase
    end else begin
      step_d = step_q;
    end

    case (state_q)
      S_FADE_OUT: begin
        if (step_s && (level_q != LVL_ZERO)) begin
          level_d = level_q - FADE_W'(1);
        end else if (step_s) begin
          scene_d = next_q;
        end else begin
          level_d = level_q;
        end
      end
      S_FADE_IN: begin
        if (step_s) begin
          level_d = level_q + FADE_W'(1);
        end else begin
          level_d = level_q;
        end
      end
      default: level_d = level_q;
    endcase

    if (leave_s) begin
`ifdef SCENE_FADE_EN
      next_d  = target_s;
`else
      scene_d = target_s;
`endif
    end else begin
      next_d = next_d;
    end
  end

  // Outputs straight from registers.
  assign bus.scene_sel  = scene_q;
  assign bus.fade_level = level_q;
  assign bus.frame_tick = tick_q;

  fade_scaler u_scaler (
    .clk     (vga_clk),
    .rst_n   (reset_n),
    .level_i (level_q),
    .blank_i (bus.blank),
    .pix_r_i (bus.pix_red),
    .pix_g_i (bus.pix_green),
    .pix_b_i (bus.pix_blue),
    .red_o   (bus.red),
    .green_o (bus.green),
    .blue_o  (bus.blue)
  );

endmodule
